// File: rtl/mor1kx_store_buffer_drain_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_store_buffer_drain_pkg
//
// Shared definitions for the store buffer drain controller.
//
// Contents:
//   sb_drain_state_e          FSM encoding (IDLE=0, WRITE=1, DROP=2, SETTLE=3)
//   SB_DRAIN_WATCHDOG_BUILT   1 when the bus watchdog is compiled in
//
// Optional feature macro: MOR1KX_SB_DRAIN_WATCHDOG_EN
//   Define it to build a WDT_WIDTH-bit watchdog that turns a bus write
//   that never answers into a bus error.
// -----------------------------------------------------------------------------
package mor1kx_store_buffer_drain_pkg;

    typedef enum logic [1:0] {
        SB_IDLE   = 2'd0,
        SB_WRITE  = 2'd1,
        SB_DROP   = 2'd2,
        SB_SETTLE = 2'd3
    } sb_drain_state_e;

`ifdef MOR1KX_SB_DRAIN_WATCHDOG_EN
    localparam bit SB_DRAIN_WATCHDOG_BUILT = 1'b1;
`else
    localparam bit SB_DRAIN_WATCHDOG_BUILT = 1'b0;
`endif

endpackage

// File: rtl/mor1kx_store_buffer_drain.sv
// -----------------------------------------------------------------------------
// mor1kx_store_buffer_drain
//
// Drains the store buffer onto the data bus, one single-beat write per entry.
// Store-conditional entries are resolved against the reservation: a lost
// reservation retires the entry without any bus cycle. Bus errors pulse
// store_err_o and capture the faulting PC. sync_done_o tells the LSU that
// every buffered store has been made globally visible.
//
// Handshake: dbus_req_o is held with stable adr/dat/bsel from the first WRITE
// cycle until the cycle in which dbus_ack_i or dbus_err_i is seen; that same
// cycle pops the head (sb_read_o) and the request drops on the next cycle.
// An error takes priority over a simultaneous acknowledge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sb_empty_i               store buffer empty
//   sb_adr_i/dat_i/bsel_i    head entry address, data, byte selects
//   sb_pc_i, sb_atomic_i     head entry PC, store-conditional marker
//   sb_read_o                pop strobe to the store buffer
//   atomic_reserve_i         reservation still valid
//   atomic_done_o/flag_o     atomic retire pulse and SC success flag
//   dbus_*                   write-only data bus master port
//   store_err_o/err_pc_o     bus error pulse, PC of the faulting store
//   sync_req_i/done_o        drain-completion request/answer
//   busy_o                   controller not in IDLE
//
// Optional feature macro: MOR1KX_SB_DRAIN_WATCHDOG_EN (bus watchdog).
// -----------------------------------------------------------------------------
module mor1kx_store_buffer_drain
    import mor1kx_store_buffer_drain_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int WDT_WIDTH            = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sb_empty_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic                              sb_atomic_i,
    output logic                              sb_read_o,
    input  logic                              atomic_reserve_i,
    output logic                              atomic_done_o,
    output logic                              atomic_flag_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    output logic                              dbus_req_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
    input  logic                              sync_req_i,
    output logic                              sync_done_o,
    output logic                              busy_o
);

    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_OPERAND_WIDTH / 8;

    sb_drain_state_e state_q;
    logic [OW-1:0]   adr_q;
    logic [OW-1:0]   dat_q;
    logic [BW-1:0]   bsel_q;
    logic [OW-1:0]   pc_q;
    logic            atomic_q;
    logic [OW-1:0]   err_pc_q;

    logic in_write;
    logic wdt_timeout;
    logic resp_err;
    logic resp_ack;
    logic retire;

    assign in_write = (state_q == SB_WRITE);

`ifdef MOR1KX_SB_DRAIN_WATCHDOG_EN
    // The counter reads k-1 in the k-th WRITE cycle. The timeout fires in the
    // cycle whose increment would bring it to all-ones, so a bus that never
    // answers is errored out in WRITE cycle 2**WDT_WIDTH-1.
    localparam logic [WDT_WIDTH-1:0] WDT_ONES = {WDT_WIDTH{1'b1}};
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_ONES - WDT_WIDTH'(1);

    logic [WDT_WIDTH-1:0] wdt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q <= '0;
        end else if (in_write) begin
            wdt_q <= wdt_q + WDT_WIDTH'(1);
        end else begin
            // Held at zero outside WRITE, so every entry starts from a clear count.
            wdt_q <= '0;
        end
    end

    assign wdt_timeout = in_write && (wdt_q == WDT_LAST);
`else
    assign wdt_timeout = 1'b0;
`endif

    // Error (or watchdog expiry) wins over a same-cycle acknowledge.
    assign resp_err = in_write && (dbus_err_i || wdt_timeout);
    assign resp_ack = in_write && dbus_ack_i && !resp_err;
    assign retire   = resp_err || resp_ack || (state_q == SB_DROP);

    // The pulses are qualified with rst so a reset that lands on a bus
    // response neither pops the FIFO nor reports anything.
    assign sb_read_o      = !rst && retire;
    assign atomic_done_o  = !rst && atomic_q && retire;
    assign atomic_flag_o  = !rst && atomic_q && resp_ack;
    assign store_err_o    = !rst && resp_err;
    assign dbus_req_o     = !rst && in_write;
    assign busy_o         = !rst && (state_q != SB_IDLE);
    assign dbus_adr_o     = adr_q;
    assign dbus_dat_o     = dat_q;
    assign dbus_bsel_o    = bsel_q;
    assign store_err_pc_o = err_pc_q;

    // A push visible in the same cycle clears sb_empty_i, so sync waits for it.
    assign sync_done_o = sync_req_i && sb_empty_i && (state_q == SB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SB_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            bsel_q   <= '0;
            pc_q     <= '0;
            atomic_q <= 1'b0;
            err_pc_q <= '0;
        end else begin
            case (state_q)
                SB_IDLE: begin
                    if (!sb_empty_i) begin
                        adr_q    <= sb_adr_i;
                        dat_q    <= sb_dat_i;
                        bsel_q   <= sb_bsel_i;
                        pc_q     <= sb_pc_i;
                        atomic_q <= sb_atomic_i;
                        // A store-conditional without a reservation never
                        // reaches the bus.
                        if (!sb_atomic_i || atomic_reserve_i) begin
                            state_q <= SB_WRITE;
                        end else begin
                            state_q <= SB_DROP;
                        end
                    end
                end
                SB_WRITE: begin
                    if (resp_err) begin
                        err_pc_q <= pc_q;
                    end
                    if (resp_err || resp_ack) begin
                        state_q <= SB_SETTLE;
                    end
                end
                SB_DROP: begin
                    state_q <= SB_SETTLE;
                end
                SB_SETTLE: begin
                    // The FIFO read port is registered; the new head is only
                    // valid one cycle after the pop.
                    state_q <= SB_IDLE;
                end
                default: begin
                    state_q <= SB_IDLE;
                end
            endcase
        end
    end

endmodule
